instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
Sequential instruction encoder, the inverse of the main/ALU decoder. It accepts symbolic instruction beats (mnemonic code plus register and immediate fields) over a valid/ready stream. Each beat is packed into a 32-bit MIPS word and written into instruction memory at consecutive addresses. Used by the bench and boot path to load programs into imem.

Parameters:
ADDR_W, 8, imem word-address width; DEPTH = 2**ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins (or restarts) a program load
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready at clk edge
in_op  in  4  0 ADD, 1 SUB, 2 SLT, 3 MUL, 4 LW, 5 SW, 6 ADDI, 7 BEQ, 8 J, 9-15 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R-type only)
in_imm  in  16  immediate (I-type only)
in_target  in  26  jump target (J only)
in_last  in  1  marks final beat of program
imem_we  out  1  write strobe, one cycle per encoded word
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  encoded instruction
busy  out  1  high in LOAD
done  out  1  program loaded; level until next start
err  out  1  illegal op or overflow; sticky until start or reset
count  out  ADDR_W+1  words written since start

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, count = 0; write pointer = BASE_ADDR.
- FSM states: IDLE, LOAD, DONE, ERR.
- Any state, start = 1: next state LOAD, pointer = BASE_ADDR, count = 0, done = err = 0. A write registered on the previous edge still issues.
- IDLE, DONE, ERR: in_ready = 0; only start is honoured.
- LOAD: in_ready = 1 (registered-free, combinational from state).
- Encoding:
  - R-type (ops 0-3): {6'b000000, rs, rt, rd, 5'b0, funct}; funct is ADD 100000, SUB 100010, SLT 101010, MUL 011100.
  - I-type: {opcode, rs, rt, imm}; opcode is LW 100011, SW 101011, ADDI 001000, BEQ 000100.
  - J: {6'b000010, target}.
  - Unused input fields are ignored.
- Latency: a beat accepted at edge N drives imem_we = 1 with imem_addr/imem_wdata during cycle N+1, so throughput is 1 word/cycle.
- At the acceptance edge, pointer and count increment. imem_we deasserts the cycle after any cycle with no accept.
- Legal beat with in_last: word is written; next state DONE, done = 1.
- Illegal in_op: no write, count unchanged; next state ERR, err = 1. The in_last flag on that beat is ignored.
- Overflow: a legal beat accepted when count == DEPTH-1 without in_last is written to the last slot; next state ERR, err = 1. The pointer never wraps.
- Accepted beat with start asserted in the same cycle: start wins and the beat is discarded, with no write.
- rst_n low mid-stream: immediate return to reset values; any pending write is dropped.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

Test Plan:
1. Reset, start, then one beat ADD rs=1 rt=2 rd=3 with in_last -> next cycle imem_we=1, addr 0, data 0x00221820; then done=1, count=1, in_ready=0.
2. Back-to-back beats LW rt=8 rs=29 imm=4; SW rt=9 rs=0 imm=8; ADDI rt=5 imm=7; BEQ rs=1 rt=2 imm=0xFFFF; MUL rd=4 rs=2 rt=3; J target=0x10 with last -> addrs 0..5 get 0x8FA80004, 0xAC090008, 0x20050007, 0x1022FFFF, 0x0043201C, 0x08000010 on consecutive cycles; count=6, done=1.
3. Illegal op 12 after two legal beats -> no third write, err=1, state ERR, count=2; a later start clears err.
4. ADDR_W=2, five legal beats, no last -> writes at addrs 0..3, err=1 after the fourth, fifth beat not accepted.
5. Valid gaps plus start pulsed mid-load -> imem_we low in gap cycles; after restart, next word lands at BASE_ADDR and count restarts at 0.
6. rst_n pulled low while imem_we=1 -> all outputs 0 immediately, state IDLE, in_ready=0 after release until start.

Source files
------------

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
//   Packs symbolic instruction beats into 32-bit MIPS words and writes them
//   to instruction memory at consecutive word addresses. Used by the bench
//   and boot path to load programs into imem.
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   start                 one-cycle pulse, begins/restarts a program load
//   in_valid / in_ready   beat handshake (in_ready high only in LOAD)
//   in_op                 0 ADD 1 SUB 2 SLT 3 MUL 4 LW 5 SW 6 ADDI 7 BEQ 8 J
//   in_rs/in_rt/in_rd     register fields
//   in_imm / in_target    I-type immediate / J-type target
//   in_last               final beat of the program
//   imem_we/addr/wdata    registered write port, one word per accepted beat
//   busy / done / err     status levels (LOAD / DONE / ERR)
//   count                 words written since start
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | accepting beats, one word written per beat
// DONE  | last beat written, waiting for start
// ERR   | illegal op or imem overflow, waiting for start
module instr_stream_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic                legal;
  logic [31:0]         word;
  logic                at_last;

  // Combinational encoder; unused fields of each format are simply not used.
  always_comb begin
    legal = 1'b1;
    word  = '0;
    unique case (in_op)
      4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd1:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd2:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd3:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b011100};
      4'd4:    word = {6'b100011, in_rs, in_rt, in_imm};
      4'd5:    word = {6'b101011, in_rs, in_rt, in_imm};
      4'd6:    word = {6'b001000, in_rs, in_rt, in_imm};
      4'd7:    word = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:    word = {6'b000010, in_target};
      default: legal = 1'b0;
    endcase
  end

  // The last writable slot is reached either by count or, with a nonzero
  // base, by the pointer hitting the top of imem; the pointer never wraps.
  assign at_last = (count_q == LAST_CNT) || (ptr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (start) begin
      // start wins over a beat presented in the same cycle
      state_d = LOAD;
      ptr_d   = BASE;
      count_d = '0;
    end else if (state_q == LOAD && in_valid) begin
      if (!legal) begin
        state_d = ERR;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        count_d = count_q + 1'b1;
        if (!at_last) ptr_d = ptr_q + 1'b1;
        if (in_last)      state_d = DONE;
        else if (at_last) state_d = ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= BASE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;

  logic        clk, rst_n;
  logic [3:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] tgt;

  logic        start_a, valid_a, last_a, ready_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;

  logic        start_b, valid_b, last_b, ready_b, we_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int checks = 0;
  int failures = 0;
  logic [39:0] q_a[$];
  logic [39:0] q_b[$];

  instr_stream_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(tgt),
    .in_last(last_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .err(err_a), .count(count_a));

  instr_stream_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(tgt),
    .in_last(last_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b), .count(count_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop an expected {addr,word} on every write strobe.
  always @(negedge clk) begin
    if (rst_n && we_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_write actual_addr=%0h actual_data=%0h", addr_a, wdata_a);
      end else begin
        logic [39:0] e;
        e = q_a.pop_front();
        chk("a_addr", 64'(addr_a), 64'(e[39:32]));
        chk("a_data", 64'(wdata_a), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && we_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_write actual_addr=%0h actual_data=%0h", addr_b, wdata_b);
      end else begin
        logic [39:0] e;
        e = q_b.pop_front();
        chk("b_addr", 64'(addr_b), 64'(e[39:32]));
        chk("b_data", 64'(wdata_b), 64'(e[31:0]));
      end
    end
  end

  // Present one beat for one cycle (called at a negedge, returns at the next).
  task automatic beat(input bit b, input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                      input bit last, input bit wr, input logic [7:0] a, input logic [31:0] w);
    op = o; rs = s; rt = t; rd = d; imm = im; tgt = tg;
    if (b) begin valid_b = 1'b1; last_b = last; end
    else   begin valid_a = 1'b1; last_a = last; end
    if (wr) begin
      if (b) q_b.push_back({a, w});
      else   q_a.push_back({a, w});
    end
    @(negedge clk);
    valid_a = 1'b0; last_a = 1'b0;
    valid_b = 1'b0; last_b = 1'b0;
  endtask

  task automatic pulse_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; valid_a = 0; last_a = 0;
    start_b = 0; valid_b = 0; last_b = 0;
    op = 0; rs = 0; rt = 0; rd = 0; imm = 0; tgt = 0;
    repeat (2) @(negedge clk);
    chk("rst_status", {ready_a, we_a, busy_a, done_a, err_a}, 5'b0);
    chk("rst_addr_data_count", {addr_a, wdata_a, count_a}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ready_a, 1'b0);

    // 1: single ADD with last
    pulse_start(0);
    chk("load_busy", {busy_a, ready_a}, 2'b11);
    beat(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h0, 1, 1, 8'd0, 32'h00221820);
    chk("t1_done", done_a, 1'b1);
    chk("t1_count", count_a, 9'd1);
    chk("t1_ready", ready_a, 1'b0);

    // 2: back-to-back program; unused fields carry junk
    pulse_start(0);
    chk("t2_restart_done", done_a, 1'b0);
    beat(0, 4'd4, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h3, 0, 1, 8'd0, 32'h8FA80004);
    beat(0, 4'd5, 5'd0,  5'd9, 5'd7,  16'h0008, 26'h5, 0, 1, 8'd1, 32'hAC090008);
    beat(0, 4'd6, 5'd0,  5'd5, 5'd1,  16'h0007, 26'h0, 0, 1, 8'd2, 32'h20050007);
    beat(0, 4'd7, 5'd1,  5'd2, 5'd0,  16'hFFFF, 26'h0, 0, 1, 8'd3, 32'h1022FFFF);
    beat(0, 4'd3, 5'd2,  5'd3, 5'd4,  16'h5555, 26'h0, 0, 1, 8'd4, 32'h0043201C);
    beat(0, 4'd8, 5'd9,  5'd9, 5'd9,  16'h1111, 26'h10, 1, 1, 8'd5, 32'h08000010);
    chk("t2_count", count_a, 9'd6);
    chk("t2_done", done_a, 1'b1);

    // 3: illegal op after two legal beats
    pulse_start(0);
    beat(0, 4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 1, 8'd0, 32'h00853022);
    beat(0, 4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 0, 1, 8'd1, 32'h00E84820);
    beat(0, 4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1, 0, 8'd0, 32'h0);
    chk("t3_err_state", {err_a, done_a, busy_a, ready_a}, 4'b1000);
    chk("t3_count", count_a, 9'd2);
    chk("t3_no_write", we_a, 1'b0);
    @(negedge clk);
    chk("t3_err_sticky", err_a, 1'b1);
    pulse_start(0);
    chk("t3_err_cleared", {err_a, busy_a}, 2'b01);
    chk("t3_count_cleared", count_a, 9'd0);

    // 5: valid gaps, then start mid-load discards the concurrent beat
    beat(0, 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 1, 8'd0, 32'h0022182A);
    @(negedge clk);
    chk("t5_gap1_we", we_a, 1'b0);
    @(negedge clk);
    chk("t5_gap2_we", we_a, 1'b0);
    beat(0, 4'd6, 5'd3, 5'd4, 5'd0, 16'h1234, 26'h0, 0, 1, 8'd1, 32'h20641234);
    start_a = 1'b1;
    beat(0, 4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0, 0, 8'd0, 32'h0);
    start_a = 1'b0;
    chk("t5_discard_we", we_a, 1'b0);
    chk("t5_restart_count", count_a, 9'd0);
    chk("t5_restart_busy", busy_a, 1'b1);
    beat(0, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1, 1, 8'd0, 32'h0BFFFFFF);
    chk("t5_done_count", {done_a, count_a}, {1'b1, 9'd1});

    // 6: reset while a write is on the port
    pulse_start(0);
    beat(0, 4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0, 1, 8'd0, 32'h00210820);
    chk("t6_we_before_rst", we_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs", {ready_a, we_a, busy_a, done_a, err_a, addr_a, wdata_a, count_a}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_idle_after_rst", {ready_a, we_a, busy_a, count_a}, '0);
    end
    valid_a = 1'b0;

    // 4: overflow on a 4-word imem
    pulse_start(1);
    beat(1, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1, 0, 1, 8'd0, 32'h08000001);
    beat(1, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2, 0, 1, 8'd1, 32'h08000002);
    beat(1, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3, 0, 1, 8'd2, 32'h08000003);
    chk("t4_not_yet_err", err_b, 1'b0);
    beat(1, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 0, 1, 8'd3, 32'h08000004);
    chk("t4_err", {err_b, ready_b}, 2'b10);
    chk("t4_count", count_b, 3'd4);
    beat(1, 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h5, 0, 0, 8'd0, 32'h0);
    chk("t4_fifth_no_write", we_b, 1'b0);
    chk("t4_count_hold", count_b, 3'd4);

    repeat (2) @(negedge clk);
    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
